// File: rtl/axi_pkg.sv
// Shared AXI4 constants, writer state encoding and the AxSIZE helper.
package axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        XFER  = 2'd2,
        RESP  = 2'd3
    } wr_state_e;

    // AxSIZE encodes log2 of the beat size in bytes.
    function automatic logic [2:0] axsize_of(input int unsigned bytes);
        logic [2:0] size;
        size = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd1 << i) == bytes) begin
                size = 3'(i);
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/axi_word_writer_if.sv
// AXI4 write-channel bundle (AW, W, B) between the word writer and DDR.
// Every channel transfers on a cycle where valid && ready are both high; the
// source holds valid and its payload stable until that cycle and never waits on ready.
interface axi_word_writer_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_word_writer.sv
// Pops packed words from the async FIFO and writes each one to DDR as a
// single-beat AXI4 write at a linearly advancing, region-wrapped address.
module axi_word_writer
    import axi_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 256,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter logic [ADDR_WIDTH-1:0] REGION_BYTES = ADDR_WIDTH'(32'h0001_0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    axi_word_writer_if.master     m,
    output logic                  busy,
    output logic [31:0]           words_written,
    output logic                  wr_err,
    output wr_state_e             dbg_state_o
);

    localparam int                    STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] END_ADDR   = BASE_ADDR + REGION_BYTES;

    wr_state_e             state_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  bready_q;
    logic                  aw_done_q;
    logic                  w_done_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [ADDR_WIDTH-1:0] awaddr_d;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [31:0]           count_q;
    logic                  err_q;
    logic                  aw_hs;
    logic                  w_hs;

    assign aw_hs    = awvalid_q && m.awready;
    assign w_hs     = wvalid_q && m.wready;
    assign addr_inc = awaddr_q + WORD_BYTES;
    assign awaddr_d = (addr_inc == END_ADDR) ? BASE_ADDR : addr_inc;

    // The pop is decoded from the state register so the registered FIFO output
    // lands exactly in the single FETCH cycle.
    assign fifo_r_en = !rst && (state_q == IDLE) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= BASE_ADDR;
            wdata_q   <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    wdata_q   <= fifo_data;
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    state_q   <= XFER;
                end
                XFER: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    // AW and W may finish in either order or together.
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        bready_q <= 1'b1;
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    if (m.bvalid && bready_q) begin
                        bready_q <= 1'b0;
                        count_q  <= count_q + 32'd1;
                        err_q    <= err_q || (m.bresp != AXI_RESP_OKAY);
                        awaddr_q <= awaddr_d;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m.awaddr  = awaddr_q;
    assign m.awlen   = 8'd0;
    assign m.awsize  = axsize_of(int'(STRB_WIDTH));
    assign m.awburst = AXI_BURST_INCR;
    assign m.awvalid = awvalid_q;
    assign m.wdata   = wdata_q;
    assign m.wstrb   = '1;
    assign m.wlast   = 1'b1;
    assign m.wvalid  = wvalid_q;
    assign m.bready  = bready_q;

    assign busy          = (state_q != IDLE);
    assign words_written = count_q;
    assign wr_err        = err_q;
    assign dbg_state_o   = state_q;

endmodule

// File: doc/axi_word_writer.md
Name: axi_word_writer

Overview:
- Downstream consumer of the word async FIFO, running entirely in the FIFO read-clock domain.
- Pops one 256-bit packed word at a time and issues it to DDR as a single-beat AXI4 write.
- Target address runs linearly from BASE_ADDR and wraps within a REGION_BYTES window.
- Reports a count of completed writes and a sticky error flag for SLVERR/DECERR responses.

Parameters:
- DATA_WIDTH, 256, word width; must match the packer/async FIFO width.
- ADDR_WIDTH, 32, AXI address width.
- BASE_ADDR, 32'h0000_0000, first write address; must be aligned to DATA_WIDTH/8.
- REGION_BYTES, 32'h0001_0000, wrap window size; must be a multiple of DATA_WIDTH/8.

Ports:
- clk  in  1  single clock (async FIFO read clock)
- rst  in  1  synchronous, active-high reset
- fifo_empty  in  1  async FIFO empty flag
- fifo_data  in  DATA_WIDTH  async FIFO data_out; registered, valid the cycle after fifo_r_en
- fifo_r_en  out  1  FIFO pop, one-cycle pulse
- m_awaddr  out  ADDR_WIDTH  write address
- m_awlen  out  8  constant 0 (single beat)
- m_awsize  out  3  constant log2(DATA_WIDTH/8) (5 for 256)
- m_awburst  out  2  constant 2'b01 (INCR)
- m_awvalid  out  1  address valid
- m_awready  in  1  address ready
- m_wdata  out  DATA_WIDTH  write data
- m_wstrb  out  DATA_WIDTH/8  constant all ones
- m_wlast  out  1  constant 1
- m_wvalid  out  1  data valid
- m_wready  in  1  data ready
- m_bresp  in  2  write response
- m_bvalid  in  1  response valid
- m_bready  out  1  response ready
- busy  out  1  high in any state other than IDLE
- words_written  out  32  count of completed writes (B handshake received)
- wr_err  out  1  sticky; set on bresp != 2'b00

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; fifo_r_en=0, awvalid=0, wvalid=0, bready=0, busy=0, words_written=0, wr_err=0, awaddr=BASE_ADDR, wdata=0.
- Reset asserted mid-transaction aborts at once to the reset values. Bench AXI slave is reset together with the block.
- IDLE: if !fifo_empty, pulse fifo_r_en for one cycle and go to FETCH.
- FETCH: one wait cycle for FIFO read latency. Then:
  - latch fifo_data into wdata;
  - assert awvalid and wvalid in the same cycle;
  - go to XFER.
- XFER: AW and W are independent handshakes.
  - Drop awvalid after the cycle with awvalid&awready; drop wvalid after wvalid&wready.
  - Either may complete first, or both in the same cycle; track each with a done flag.
  - awaddr and wdata stay stable while the matching valid is high.
  - When both are done, go to RESP with bready=1.
- RESP: wait for bvalid. On bvalid&bready:
  - bready=0;
  - words_written += 1, wrapping at 2^32;
  - wr_err |= (bresp != 0);
  - awaddr += DATA_WIDTH/8; if the result equals BASE_ADDR+REGION_BYTES, load BASE_ADDR instead;
  - go to IDLE.
- Exactly one outstanding transaction. fifo_r_en is never asserted outside IDLE or while fifo_empty=1.
- Best case: 4 cycles per word (IDLE, FETCH, XFER, RESP) with awready=wready=bvalid=1. Back-to-back words therefore give one fifo_r_en every 4 cycles.
- Error response: the write still counts, the address still advances, and data is not retried.
- A FIFO going empty between words makes the block sit in IDLE with busy=0 and no AXI valids asserted.

Decomposition:
- Shared package axi_pkg holds:
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - AXI_BURST_INCR;
  - the state enum typedef (IDLE, FETCH, XFER, RESP);
  - function axsize_of(bytes).
- No sub-module. A single FSM plus address, counter and flag registers is natural.

Test Plan:
- Single word: FIFO holds 256'h0123..EF, slave ready always -> one AW at 0x0 with awlen=0, awsize=5; wdata equals the word; words_written=1; busy back to 0 after 4 cycles.
- Back-to-back: 5 words queued -> awaddr sequence 0x00,0x20,0x40,0x60,0x80; data in FIFO order; exactly 5 fifo_r_en pulses; words_written=5.
- Skewed handshakes:
  - awready delayed 3 cycles with wready immediate -> wvalid drops after 1 cycle, awvalid holds with a stable address, then RESP;
  - the mirror case (wready delayed, awready immediate) behaves the same way;
  - simultaneous AW/W completion also reaches RESP.
- Wrap: REGION_BYTES=0x60 with 4 words -> addresses 0x00,0x20,0x40,0x00.
- Error: slave returns bresp=2'b10 on the 2nd of 3 writes -> wr_err=1 and stays 1; words_written=3; 3rd write goes to 0x40.
- Reset mid-XFER: rst asserted while awvalid=1 -> next cycle all valids=0, awaddr=BASE_ADDR, words_written=0, state IDLE. After release, the next queued word is written to BASE_ADDR.
